// File: rtl/matrix_mult_nxn.sv
// Purpose: UART-fed NxN unsigned 8-bit matrix multiplier. Collects A then B row-major
//          from rx bytes, computes R = A*B with one MAC per cycle, streams R row-major out.
// Latency: state changes on the edge sampling the last B byte; N^3 compute cycles;
//          first tx_dv one cycle after entering SEND (if tx_active low).
// Backpressure: one byte outstanding at a time; next byte waits for tx_done and tx_active=0.
//          rx bytes arriving during COMPUTE/SEND are discarded and flagged on rx_drop.
// Ports: clk/rst_n (async active-low); rx_dv/rx_byte receive stream; abort synchronous
//        frame discard; tx_dv/tx_byte/tx_done/tx_active transmit handshake;
//        busy (not idle), done (frame complete pulse), rx_drop, debug (state code).
module matrix_mult_nxn #(
    parameter int N     = 2,
    parameter int SAT   = 0,
    parameter int ACC_W = 16 + $clog2(N)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       abort,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    input  logic       tx_active,
    output logic       busy,
    output logic       done,
    output logic       rx_drop,
    output logic [2:0] debug
);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int CW = $clog2(N);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("matrix_mult_nxn: N must be in 2..8");
    end
    if (ACC_W < 16 + $clog2(N)) begin : g_bad_acc
        $error("matrix_mult_nxn: ACC_W too narrow for N");
    end

    // Encoding doubles as the debug state code.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV_A  = 3'd1,
        S_RECV_B  = 3'd2,
        S_COMPUTE = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       a_mem [NN];
    logic [7:0]       b_mem [NN];
    logic [7:0]       r_mem [NN];
    logic [IW-1:0]    rx_cnt;
    logic [IW-1:0]    tx_cnt;
    logic [CW-1:0]    i, j, k;
    logic [ACC_W-1:0] acc;
    logic             pending;   // a byte has been handed to the UART, awaiting tx_done

    logic [IW-1:0]    a_idx, b_idx, r_idx;
    logic [15:0]      prod;
    logic [ACC_W-1:0] sum;
    logic [7:0]       sat_val, res;
    logic             rx_last, tx_last, k_last, j_last, i_last, mac_last;

    assign a_idx = IW'(i) * IW'(N) + IW'(k);
    assign b_idx = IW'(k) * IW'(N) + IW'(j);
    assign r_idx = IW'(i) * IW'(N) + IW'(j);

    assign prod    = {8'd0, a_mem[a_idx]} * {8'd0, b_mem[b_idx]};
    assign sum     = acc + ACC_W'(prod);
    assign sat_val = (sum > ACC_W'(255)) ? 8'hFF : sum[7:0];
    assign res     = (SAT != 0) ? sat_val : sum[7:0];

    assign rx_last  = (rx_cnt == IW'(NN - 1));
    assign tx_last  = (tx_cnt == IW'(NN - 1));
    assign k_last   = (k == CW'(N - 1));
    assign j_last   = (j == CW'(N - 1));
    assign i_last   = (i == CW'(N - 1));
    assign mac_last = k_last && j_last && i_last;

    assign debug = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (rx_dv) state_d = S_RECV_A;
            S_RECV_A:  if (rx_dv && rx_last) state_d = S_RECV_B;
            S_RECV_B:  if (rx_dv && rx_last) state_d = S_COMPUTE;
            S_COMPUTE: if (mac_last) state_d = S_SEND;
            S_SEND:    if (pending && tx_done && tx_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // abort in idle is a no-op, so forcing idle unconditionally is safe
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_dv   <= 1'b0;
            tx_byte <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_drop <= 1'b0;
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            pending <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                a_mem[n] <= 8'd0;
                b_mem[n] <= 8'd0;
                r_mem[n] <= 8'd0;
            end
        end else begin
            tx_dv   <= 1'b0;
            done    <= 1'b0;
            rx_drop <= 1'b0;
            busy    <= (state_d != S_IDLE);
            if (abort && state_q != S_IDLE) begin
                // tx_byte is left alone: a byte already with the UART is not retracted
                rx_cnt  <= '0;
                tx_cnt  <= '0;
                i       <= '0;
                j       <= '0;
                k       <= '0;
                acc     <= '0;
                pending <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_dv) begin
                            a_mem[0] <= rx_byte;
                            rx_cnt   <= IW'(1);
                        end
                    end
                    S_RECV_A: begin
                        if (rx_dv) begin
                            a_mem[rx_cnt] <= rx_byte;
                            rx_cnt        <= rx_last ? '0 : rx_cnt + IW'(1);
                        end
                    end
                    S_RECV_B: begin
                        if (rx_dv) begin
                            b_mem[rx_cnt] <= rx_byte;
                            rx_cnt        <= rx_last ? '0 : rx_cnt + IW'(1);
                            if (rx_last) begin
                                i   <= '0;
                                j   <= '0;
                                k   <= '0;
                                acc <= '0;
                            end
                        end
                    end
                    S_COMPUTE: begin
                        rx_drop <= rx_dv;
                        if (k_last) begin
                            // final term folds into the written value; acc restarts
                            r_mem[r_idx] <= res;
                            acc          <= '0;
                            k            <= '0;
                            if (j_last) begin
                                j <= '0;
                                i <= i_last ? '0 : i + CW'(1);
                            end else begin
                                j <= j + CW'(1);
                            end
                        end else begin
                            acc <= sum;
                            k   <= k + CW'(1);
                        end
                        if (mac_last) begin
                            tx_cnt  <= '0;
                            pending <= 1'b0;
                        end
                    end
                    S_SEND: begin
                        rx_drop <= rx_dv;
                        if (pending) begin
                            if (tx_done) begin
                                pending <= 1'b0;
                                if (tx_last) begin
                                    done   <= 1'b1;
                                    tx_cnt <= '0;
                                end else begin
                                    tx_cnt <= tx_cnt + IW'(1);
                                end
                            end
                        end else if (!tx_active) begin
                            tx_byte <= r_mem[tx_cnt];
                            tx_dv   <= 1'b1;
                            pending <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matrix_mult_nxn.sv
// Bench for matrix_mult_nxn: four instances (N=2/SAT=0, N=3/SAT=1, N=3/SAT=0, N=4/SAT=0)
// share clock, reset and rx_byte; only one instance is exercised at a time, so a single
// expected-byte queue filled by a plain-arithmetic matrix model serves all of them.
module tb_matrix_mult_nxn;
    localparam int NI = 4;
    localparam logic [NI-1:0][3:0] NPK = {4'd4, 4'd3, 4'd3, 4'd2};
    localparam logic [NI-1:0][3:0] SPK = {4'd0, 4'd0, 4'd1, 4'd0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_byte;
    logic [NI-1:0] rx_dv_v, abort_v, tx_act_v, tx_done_v;
    logic [NI-1:0] tx_dv_v, busy_v, done_v, drop_v;
    logic [7:0]    tx_byte_a [NI];
    logic [2:0]    debug_a   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        matrix_mult_nxn #(.N(int'(NPK[g])), .SAT(int'(SPK[g]))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .rx_dv     (rx_dv_v[g]),
            .rx_byte   (rx_byte),
            .abort     (abort_v[g]),
            .tx_dv     (tx_dv_v[g]),
            .tx_byte   (tx_byte_a[g]),
            .tx_done   (tx_done_v[g]),
            .tx_active (tx_act_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .rx_drop   (drop_v[g]),
            .debug     (debug_a[g])
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int nof(input int g);
        return int'(NPK[g]);
    endfunction

    // ---------------- model ----------------
    int ma[64], mb[64], mr[64];
    logic [7:0] exp_q[$];

    task automatic model(input int n, input int sat);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                int s = 0;
                for (int t = 0; t < n; t++) s += ma[r*n+t] * mb[t*n+c];
                mr[r*n+c] = (sat != 0) ? ((s > 255) ? 255 : s) : (s % 256);
                exp_q.push_back(8'(mr[r*n+c]));
            end
        end
    endtask

    // ---------------- UART model: tx_done ~10 cycles after tx_dv ----------------
    initial begin
        logic [NI-1:0] pend;
        tx_done_v = '0;
        forever begin
            @(negedge clk);
            if (|tx_dv_v) begin
                pend = tx_dv_v;
                repeat (10) @(posedge clk);
                #1 tx_done_v = pend;
                @(posedge clk);
                #1 tx_done_v = '0;
            end
        end
    end

    // ---------------- compare process ----------------
    int dv_cnt[NI], done_cnt[NI], drop_cnt[NI], dbg3[NI];
    logic [NI-1:0] prev_dv = '0;

    always @(negedge clk) begin
        if (!rst_n) exp_q.delete();
        for (int g = 0; g < NI; g++) begin
            if (tx_dv_v[g]) begin
                dv_cnt[g]++;
                check("tx_dv_back_to_back", int'(prev_dv[g]), 0);
                if (exp_q.size() == 0) check("tx_dv_unexpected", 1, 0);
                else check("tx_byte", int'(tx_byte_a[g]), int'(exp_q.pop_front()));
            end
            prev_dv[g] = tx_dv_v[g];
            if (done_v[g]) done_cnt[g]++;
            if (drop_v[g]) drop_cnt[g]++;
            check("busy_vs_state", int'(busy_v[g]), int'(debug_a[g] != 3'd0));
            if (debug_a[g] == 3'd3) begin
                dbg3[g]++;
            end else begin
                if (dbg3[g] != 0 && debug_a[g] == 3'd4)
                    check("compute_cycles", dbg3[g], nof(g) ** 3);
                dbg3[g] = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int s_dv, s_done, s_drop;

    task automatic send_byte(input int g, input int v);
        rx_byte    = 8'(v);
        rx_dv_v[g] = 1'b1;
        @(posedge clk); #1;
        rx_dv_v[g] = 1'b0;
    endtask

    task automatic start_frame(input int g);
        int n = nof(g);
        model(n, int'(SPK[g]));
        s_dv = dv_cnt[g]; s_done = done_cnt[g]; s_drop = drop_cnt[g];
        for (int x = 0; x < n*n; x++) send_byte(g, ma[x]);
        for (int x = 0; x < n*n; x++) send_byte(g, mb[x]);
    endtask

    task automatic wait_debug(input int g, input int st, input string nm);
        int c = 0;
        while (int'(debug_a[g]) != st && c < 2000) begin @(posedge clk); #1; c++; end
        check(nm, int'(debug_a[g]), st);
    endtask

    task automatic finish_frame(input int g);
        int c = 0;
        int n = nof(g);
        while (done_cnt[g] == s_done && c < 3000) begin @(posedge clk); #1; c++; end
        check("done_pulses", done_cnt[g] - s_done, 1);
        check("tx_dv_count", dv_cnt[g] - s_dv, n*n);
        check("exp_queue_drained", exp_q.size(), 0);
        check("busy_after_done", int'(busy_v[g]), 0);
        check("debug_after_done", int'(debug_a[g]), 0);
    endtask

    task automatic load_ab(input int n, input int a0, input int b0);
        for (int x = 0; x < n*n; x++) begin ma[x] = a0 + x; mb[x] = b0 + x; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rx_dv_v = '0; abort_v = '0; tx_act_v = '0; rx_byte = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("reset_debug", int'(debug_a[g]), 0);
            check("reset_busy", int'(busy_v[g]), 0);
            check("reset_tx_dv", int'(tx_dv_v[g]), 0);
            check("reset_tx_byte", int'(tx_byte_a[g]), 0);
            check("reset_done", int'(done_v[g]), 0);
            check("reset_rx_drop", int'(drop_v[g]), 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // N=2 basic: [1 2;3 4]*[5 6;7 8]
        load_ab(2, 1, 5);
        start_frame(0);
        check("model_r0", mr[0], 19); check("model_r1", mr[1], 22);
        check("model_r2", mr[2], 43); check("model_r3", mr[3], 50);
        finish_frame(0);

        // N=3 all 255, saturating and truncating
        for (int x = 0; x < 9; x++) begin ma[x] = 255; mb[x] = 255; end
        start_frame(1);
        check("model_sat", mr[0], 255);
        finish_frame(1);
        start_frame(2);
        check("model_trunc", mr[4], 3);
        finish_frame(2);

        // N=4 identity * 0..15
        for (int x = 0; x < 16; x++) begin ma[x] = (x % 5 == 0) ? 1 : 0; mb[x] = x; end
        start_frame(3);
        check("model_ident5", mr[5], 5); check("model_ident15", mr[15], 15);
        finish_frame(3);

        // dropped bytes during COMPUTE and SEND
        ma[0] = 2; ma[1] = 0; ma[2] = 0; ma[3] = 2;
        for (int x = 0; x < 4; x++) mb[x] = x + 1;
        start_frame(0);
        check("model_scale", mr[3], 8);
        send_byte(0, 'hAA);
        wait_debug(0, 4, "reach_send_for_drop");
        send_byte(0, 'hAA);
        finish_frame(0);
        check("rx_drop_pulses", drop_cnt[0] - s_drop, 2);
        load_ab(2, 1, 5);
        start_frame(0);
        finish_frame(0);

        // tx_active held high for 50 cycles after SEND entered
        tx_act_v[0] = 1'b1;
        load_ab(2, 2, 3);
        start_frame(0);
        wait_debug(0, 4, "reach_send_for_active");
        repeat (50) begin @(posedge clk); #1; end
        check("no_tx_dv_while_active", dv_cnt[0] - s_dv, 0);
        tx_act_v[0] = 1'b0;
        @(posedge clk); #1;
        check("tx_dv_after_active_drop", int'(tx_dv_v[0]), 1);
        finish_frame(0);

        // abort after three bytes of A
        send_byte(0, 9); send_byte(0, 9); send_byte(0, 9);
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        check("abort_debug", int'(debug_a[0]), 0);
        check("abort_busy", int'(busy_v[0]), 0);
        load_ab(2, 1, 5);
        start_frame(0);
        finish_frame(0);

        // reset mid-SEND
        load_ab(2, 4, 1);
        start_frame(0);
        wait_debug(0, 4, "reach_send_for_reset");
        begin
            int c = 0;
            while (dv_cnt[0] == s_dv && c < 100) begin @(posedge clk); #1; c++; end
            check("first_tx_before_reset", dv_cnt[0] - s_dv, 1);
        end
        rst_n = 1'b0;
        #1;
        check("reset_mid_debug", int'(debug_a[0]), 0);
        check("reset_mid_busy", int'(busy_v[0]), 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        ma[0] = 3; ma[1] = 1; ma[2] = 4; ma[3] = 1;
        mb[0] = 5; mb[1] = 9; mb[2] = 2; mb[3] = 6;
        start_frame(0);
        check("model_post_reset0", mr[0], 17); check("model_post_reset1", mr[1], 33);
        check("model_post_reset2", mr[2], 22); check("model_post_reset3", mr[3], 42);
        finish_frame(0);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
